stream_packet_tracker: RTL and testbench

// - Parametrised successor to the single-cycle end-of-packet signal block. Sinks a valid/ready/last

---
 rtl/stream_packet_tracker.sv | 135 +++++++++++++
 tb/tb_stream_packet_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_packet_tracker.sv
`default_nettype none
// ============================================================================
// Module   : stream_packet_tracker
// Purpose  : Counts beats of a valid/ready/last stream and reports packet length,
//            overflow error and optional byte checksum (STREAM_PACKET_TRACKER_CHECKSUM_EN).
// Revision : 1.0
// ============================================================================
module stream_packet_tracker #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 256,
  localparam int CW        = $clog2(MAX_BEATS + 1)
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  valid,
  input  logic                  last,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  signal,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [CW-1:0]         result_length,
  output logic                  result_error,
  output logic [7:0]            result_checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_MAX = CW'(MAX_BEATS);

  state_t         r_state;
  state_t         w_next;
  logic           w_accept;
  logic           w_release;
  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_next;
  logic           r_error;
  logic           w_error_next;
  logic           r_signal;
  logic [CW-1:0]  r_length;
  logic           r_res_error;

  assign ready        = (r_state != S_HOLD);
  assign result_valid = (r_state == S_HOLD);
  assign w_accept     = valid & ready;
  assign w_release    = (r_state == S_HOLD) & result_ready;

  // Count and error are zero while IDLE, so one datapath serves first and later beats.
  assign w_count_next = (r_count == C_MAX) ? r_count : r_count + CW'(1);
  assign w_error_next = r_error | (r_count == C_MAX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = last ? S_HOLD : S_BUSY;
      S_BUSY:  if (w_accept && last) w_next = S_HOLD;
      S_HOLD:  if (result_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_error     <= 1'b0;
      r_signal    <= 1'b0;
      r_length    <= '0;
      r_res_error <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_signal <= w_accept & last;
      if (w_accept) begin
        if (last) begin
          r_count     <= '0;
          r_error     <= 1'b0;
          r_length    <= w_count_next;
          r_res_error <= w_error_next;
        end else begin
          r_count <= w_count_next;
          r_error <= w_error_next;
        end
      end else if (w_release) begin
        r_length    <= '0;
        r_res_error <= 1'b0;
      end
    end
  end

  assign signal        = r_signal;
  assign result_length = r_length;
  assign result_error  = r_res_error;

`ifdef STREAM_PACKET_TRACKER_CHECKSUM_EN
  logic [7:0] w_beat_sum;
  logic [7:0] r_sum;
  logic [7:0] r_checksum;

  always_comb begin
    w_beat_sum = 8'h00;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      w_beat_sum = w_beat_sum + data[i*8 +: 8];
    end
  end

  // Dropped overflow beats still contribute to the sum.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_sum      <= 8'h00;
      r_checksum <= 8'h00;
    end else if (w_accept) begin
      if (last) begin
        r_sum      <= 8'h00;
        r_checksum <= r_sum + w_beat_sum;
      end else begin
        r_sum <= r_sum + w_beat_sum;
      end
    end else if (w_release) begin
      r_checksum <= 8'h00;
    end
  end

  assign result_checksum = r_checksum;
`else
  logic w_unused_data;
  assign w_unused_data   = ^data;
  assign result_checksum = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_packet_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_packet_tracker
// Purpose  : Directed scoreboard bench for stream_packet_tracker (16-bit data, 4 beat max).
// Revision : 1.0
// ============================================================================
module tb_stream_packet_tracker;

  localparam int DW  = 16;
  localparam int MB  = 4;
  localparam int CW  = $clog2(MB + 1);

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          valid = 1'b0;
  logic          last = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ready;
  logic          signal;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [CW-1:0] result_length;
  logic          result_error;
  logic [7:0]    result_checksum;

  typedef struct {
    logic [CW-1:0] len;
    logic          err;
    logic [7:0]    cks;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state for the packet currently being sent
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  logic [7:0] m_cks = 8'h00;

  stream_packet_tracker #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
    .clock           (clock),
    .clear           (clear),
    .valid           (valid),
    .last            (last),
    .data            (data),
    .ready           (ready),
    .signal          (signal),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_length   (result_length),
    .result_error    (result_error),
    .result_checksum (result_checksum)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_err = 1'b0;
    m_cks = 8'h00;
  endtask

  // Drives one beat and returns 1 ns after the edge that accepted it.
  task automatic beat(input logic [DW-1:0] d, input logic l);
    exp_t e;
    int   n;
    n     = 0;
    valid = 1'b1;
    data  = d;
    last  = l;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    chk("beat_ready", {31'd0, ready}, 32'd1);
    step();
    valid = 1'b0;
    last  = 1'b0;
    if (m_cnt == MB) m_err = 1'b1;
    else             m_cnt++;
    m_cks = m_cks + d[7:0] + d[15:8];
    if (l) begin
      e.len = CW'(m_cnt);
      e.err = m_err;
`ifdef STREAM_PACKET_TRACKER_CHECKSUM_EN
      e.cks = m_cks;
`else
      e.cks = 8'h00;
`endif
      sb.push_back(e);
      model_reset();
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_rvalid"}, {31'd0, result_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_len"}, 32'(result_length),   32'(e.len));
      chk({tag, "_err"}, 32'(result_error),    32'(e.err));
      chk({tag, "_cks"}, 32'(result_checksum), 32'(e.cks));
    end
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_rdy_after"},  {31'd0, ready},        32'd1);
    chk({tag, "_rv_after"},   {31'd0, result_valid}, 32'd0);
    chk({tag, "_sig_after"},  {31'd0, signal},       32'd0);
  endtask

  task automatic send_pkt(input int nbeats, input logic [DW-1:0] base);
    for (int i = 0; i < nbeats; i++) begin
      beat(base + DW'(i), (i == nbeats - 1));
    end
  endtask

  initial begin
    exp_t e;
    // Reset state
    step();
    step();
    clear = 1'b0;
    step();
    chk("rst_ready", {31'd0, ready},        32'd1);
    chk("rst_sig",   {31'd0, signal},       32'd0);
    chk("rst_rv",    {31'd0, result_valid}, 32'd0);
    chk("rst_len",   32'(result_length),    32'd0);
    chk("rst_err",   32'(result_error),     32'd0);
    chk("rst_cks",   32'(result_checksum),  32'd0);

    // Single-beat packet
    beat(16'h005A, 1'b1);
    chk("single_sig",   {31'd0, signal}, 32'd1);
    chk("single_ready", {31'd0, ready},  32'd0);
    check_result("single");
    handshake("single");

    // 4-beat packet (exactly MAX_BEATS) with result_ready held high
    result_ready = 1'b1;
    send_pkt(4, 16'h0001);
    chk("four_sig",   {31'd0, signal}, 32'd1);
    chk("four_ready", {31'd0, ready},  32'd0);
    check_result("four");
    step();
    chk("four_ready_n2", {31'd0, ready},        32'd1);
    chk("four_sig_n2",   {31'd0, signal},       32'd0);
    chk("four_rv_n2",    {31'd0, result_valid}, 32'd0);
    result_ready = 1'b0;

    // Backpressure: descriptor held, pending beat not consumed until HOLD exits
    beat(16'h00AA, 1'b0);
    beat(16'h00BB, 1'b1);
    e     = sb[0];
    valid = 1'b1;
    data  = 16'h0077;
    last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_ready", {31'd0, ready},        32'd0);
      chk("bp_rv",    {31'd0, result_valid}, 32'd1);
      chk("bp_len",   32'(result_length),    32'(e.len));
      chk("bp_cks",   32'(result_checksum),  32'(e.cks));
    end
    chk("bp_sig_low", {31'd0, signal}, 32'd0);
    check_result("bp");
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_exit_rv",    {31'd0, result_valid}, 32'd0);
    chk("bp_exit_ready", {31'd0, ready},        32'd1);
    beat(16'h0077, 1'b1);
    chk("bp_next_sig", {31'd0, signal}, 32'd1);
    check_result("bp_next");
    handshake("bp_next");

    // Overflow: 6 beats and 5 beats both saturate with error
    send_pkt(6, 16'h0001);
    check_result("ovf6");
    handshake("ovf6");
    send_pkt(5, 16'h0001);
    check_result("ovf5");
    handshake("ovf5");

    // Asynchronous clear mid-packet discards the partial packet
    beat(16'h0010, 1'b0);
    beat(16'h0020, 1'b0);
    beat(16'h0030, 1'b0);
    #2;
    clear = 1'b1;
    #1;
    chk("clr_ready", {31'd0, ready},        32'd1);
    chk("clr_rv",    {31'd0, result_valid}, 32'd0);
    #2;
    clear = 1'b0;
    model_reset();
    step();
    chk("clr_idle_rv", {31'd0, result_valid}, 32'd0);
    beat(16'h0005, 1'b0);
    beat(16'h0006, 1'b1);
    check_result("post_clr");
    handshake("post_clr");

    // Checksum wrap across both bytes of each beat
    beat(16'hFFFF, 1'b0);
    beat(16'h0002, 1'b1);
    check_result("wrap");
    handshake("wrap");

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
